// File: rtl/uart_pkg.sv
`default_nettype none
//==== uart_pkg : shared UART timing constants, receiver state encoding, vote helper ====
//==== rev 1.0 ===========================================================================
package uart_pkg;

  localparam int CLK_HZ       = 12_000_000;
  localparam int BAUD         = 9600;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_8n1_if.sv
`default_nettype none
//==== uart_rx_8n1_if : received-byte valid/ready handshake plus status flags ====
//==== rev 1.0 ===================================================================
interface uart_rx_8n1_if;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       rx_frame_err;
  logic       rx_overrun;

  modport master (
    output rx_byte, rx_valid, rx_busy, rx_frame_err, rx_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_byte, rx_valid, rx_busy, rx_frame_err, rx_overrun,
    output rx_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_sync_maj.sv
`default_nettype none
//==== uart_sync_maj : 2-flop synchroniser, 3-sample history, majority vote, start-edge detect ====
//==== rev 1.0 ====================================================================================
module uart_sync_maj
  import uart_pkg::*;
(
  input  wire logic hwclk,
  input  wire logic rst_n,
  input  wire logic rx_in,
  output logic      fall,
  output logic      maj
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [2:0] hist_q, hist_d;
  logic [1:0] live_q, live_d;
  logic       armed_q, armed_d;

  // The all-ones reset values are not real line samples; edge detection stays
  // disarmed until a genuine high has passed through the synchroniser.
  always_comb begin
    sync1_d = rx_in;
    sync2_d = sync1_q;
    hist_d  = {hist_q[1:0], sync2_q};
    live_d  = {live_q[0], 1'b1};
    armed_d = armed_q | (live_q[1] & sync2_q);
  end

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 3'b111;
      live_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      live_q  <= live_d;
      armed_q <= armed_d;
    end
  end

  assign fall = armed_q & hist_q[0] & ~sync2_q;
  assign maj  = maj3(hist_q);

endmodule
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
//==== uart_rx_8n1 : 8N1 UART receiver, mid-bit majority sampling, valid/ready byte output ====
//==== rev 1.0 ================================================================================
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input  wire logic      hwclk,
  input  wire logic      rst_n,
  input  wire logic      rx_in,
  uart_rx_8n1_if.master  rx_if
);
  import uart_pkg::*;

  localparam int            HALF_BIT  = CLKS_PER_BIT / 2;
  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          fall;
  logic          maj;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  uart_sync_maj u_sync (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .rx_in (rx_in),
    .fall  (fall),
    .maj   (maj)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = valid_q & ~rx_if.rx_ready;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d   = ST_START;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = maj ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {maj, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        // Leaving at mid-stop leaves half a bit to catch an immediately following start edge.
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!maj) begin
            ferr_d = 1'b1;
          end else if (!valid_q || rx_if.rx_ready) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_if.rx_byte      = byte_q;
  assign rx_if.rx_valid     = valid_q;
  assign rx_if.rx_busy      = (state_q != ST_IDLE);
  assign rx_if.rx_frame_err = ferr_q;
  assign rx_if.rx_overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
`default_nettype none
//==== tb_uart_rx_8n1 : directed + randomized frames checked against a frame-level receiver model ====
//==== rev 1.0 ========================================================================================
module tb_uart_rx_8n1;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic hwclk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_in = 1'b1;

  uart_rx_8n1_if bus ();

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .hwclk (hwclk),
    .rst_n (rst_n),
    .rx_in (rx_in),
    .rx_if (bus)
  );

  always #5 hwclk = ~hwclk;

  int cyc = 0;
  always @(posedge hwclk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Observed and expected events: cycle stamps and, for loads, the byte.
  int         obs_load_t[$], exp_load_t[$];
  logic [7:0] obs_load_b[$], exp_load_b[$];
  int         obs_fall[$];
  int         obs_ferr[$], exp_ferr[$];
  int         obs_ovr[$],  exp_ovr[$];

  logic       m_valid;
  logic [7:0] m_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    vectors++;
    assert ((obs >= exp - 1) && (obs <= exp + 1)) else begin
      miscompares++;
      $error("FAIL %s: observed cycle %0d expected %0d +/-1", tag, obs, exp);
    end
  endtask

  logic       v_prev = 1'b0;
  logic       r_prev = 1'b0;
  logic [7:0] b_prev = 8'h00;

  always @(negedge hwclk) begin
    if (!rst_n) begin
      v_prev <= 1'b0;
    end else begin
      if (bus.rx_valid && !v_prev) begin
        obs_load_t.push_back(cyc);
        obs_load_b.push_back(bus.rx_byte);
      end
      if (!bus.rx_valid && v_prev) obs_fall.push_back(cyc);
      if (bus.rx_frame_err) obs_ferr.push_back(cyc);
      if (bus.rx_overrun)   obs_ovr.push_back(cyc);
      if (bus.rx_valid && v_prev && !r_prev) chk("byte_hold", bus.rx_byte, b_prev);
      v_prev <= bus.rx_valid;
    end
    r_prev <= bus.rx_ready;
    b_prev <= bus.rx_byte;
  end

  // Frame-level outcome: good stop loads unless a byte is still pending and not accepted.
  task automatic model_frame(input int s, input logic [7:0] b, input logic stop_ok, input logic rdy);
    int t;
    t = s + LAT;
    if (!stop_ok) begin
      exp_ferr.push_back(t);
    end else if (!m_valid || rdy) begin
      if (!m_valid) begin
        exp_load_t.push_back(t);
        exp_load_b.push_back(b);
      end
      m_byte  = b;
      m_valid = !rdy;
    end else begin
      exp_ovr.push_back(t);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    step(n);
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    step(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    model_frame(cyc, b, stop_ok, bus.rx_ready);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
  endtask

  task automatic wait_until(input int t);
    do @(negedge hwclk); while (cyc < t);
  endtask

  task automatic end_scenario(input string tag);
    chk({tag, "_nload"}, obs_load_t.size(), exp_load_t.size());
    for (int i = 0; i < obs_load_t.size() && i < exp_load_t.size(); i++) begin
      chk_near({tag, "_load_cyc"}, obs_load_t[i], exp_load_t[i]);
      chk({tag, "_byte"}, obs_load_b[i], exp_load_b[i]);
    end
    chk({tag, "_nferr"}, obs_ferr.size(), exp_ferr.size());
    for (int i = 0; i < obs_ferr.size() && i < exp_ferr.size(); i++)
      chk_near({tag, "_ferr_cyc"}, obs_ferr[i], exp_ferr[i]);
    chk({tag, "_novr"}, obs_ovr.size(), exp_ovr.size());
    for (int i = 0; i < obs_ovr.size() && i < exp_ovr.size(); i++)
      chk_near({tag, "_ovr_cyc"}, obs_ovr[i], exp_ovr[i]);
    obs_load_t.delete(); obs_load_b.delete(); exp_load_t.delete(); exp_load_b.delete();
    obs_fall.delete(); obs_ferr.delete(); exp_ferr.delete(); obs_ovr.delete(); exp_ovr.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int         s;
    logic [7:0] b;
    logic       ok;
    int         gap;

    bus.rx_ready = 1'b1;
    m_valid      = 1'b0;
    m_byte       = 8'h00;

    // Reset state
    step(3);
    @(negedge hwclk);
    chk("rst_byte",  bus.rx_byte,      8'h00);
    chk("rst_valid", bus.rx_valid,     1'b0);
    chk("rst_busy",  bus.rx_busy,      1'b0);
    chk("rst_ferr",  bus.rx_frame_err, 1'b0);
    chk("rst_ovr",   bus.rx_overrun,   1'b0);
    @(posedge hwclk); #1;
    rst_n = 1'b1;
    idle(20);

    // Single frame '0'
    send_frame(8'h30, 1'b1);
    idle(20);
    if (obs_fall.size() > 0 && obs_load_t.size() > 0)
      chk("t1_pulse_width", obs_fall[0] - obs_load_t[0], 1);
    end_scenario("t1");

    // Glitch shorter than half a bit
    s = cyc;
    rx_in = 1'b0;
    step(3);
    rx_in = 1'b1;
    wait_until(s + 5);
    chk("glitch_busy_start", bus.rx_busy, 1'b1);
    wait_until(s + 12);
    chk("glitch_busy_idle", bus.rx_busy, 1'b0);
    wait_until(s + 212);
    @(posedge hwclk); #1;
    end_scenario("glitch");

    // Framing error
    send_frame(8'hA5, 1'b0);
    idle(30);
    @(negedge hwclk);
    chk("ferr_valid", bus.rx_valid, m_valid);
    chk("ferr_byte",  bus.rx_byte,  m_byte);
    @(posedge hwclk); #1;
    end_scenario("ferr");

    // Overrun with consumer stalled
    bus.rx_ready = 1'b0;
    send_frame(8'h41, 1'b1);
    send_frame(8'h42, 1'b1);
    idle(10);
    @(negedge hwclk);
    chk("ovr_valid", bus.rx_valid, 1'b1);
    chk("ovr_byte",  bus.rx_byte,  m_byte);
    @(posedge hwclk); #1;
    bus.rx_ready = 1'b1;
    m_valid      = 1'b0;
    @(negedge hwclk);
    chk("ovr_valid_held", bus.rx_valid, 1'b1);
    @(negedge hwclk);
    chk("ovr_valid_clear", bus.rx_valid, 1'b0);
    @(posedge hwclk); #1;
    end_scenario("ovr");

    // Back-to-back frames, no idle gap
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    end_scenario("b2b");

    // Reset during data bit 3 with the line low, then a clean frame
    b = 8'($urandom) & 8'hF7;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rx_in = b[3];
    step(8);
    rst_n = 1'b0;
    step(2);
    rst_n   = 1'b1;
    m_valid = 1'b0;
    m_byte  = 8'h00;
    step(10);
    @(negedge hwclk);
    chk("rstmid_busy", bus.rx_busy, 1'b0);
    chk("rstmid_byte", bus.rx_byte, m_byte);
    @(posedge hwclk); #1;
    idle(40);
    send_frame(8'h7E, 1'b1);
    idle(20);
    end_scenario("rstmid");

    // Randomized frames with occasional bad stop bits and random gaps
    for (int k = 0; k < 8; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok);
      gap = ok ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
      if (gap > 0) idle(gap);
    end
    idle(20);
    @(negedge hwclk);
    chk("rand_final_byte", bus.rx_byte, m_byte);
    @(posedge hwclk); #1;
    end_scenario("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
